z80_cb_shift_exec: RTL

- Multi-cycle execution unit for the CB-prefixed shift/rotate group on register operands: RLC, RRC, RL, RR, SLA, SRA, SLL, SRL.
- Accepts instruction bytes from the fetch stage over a valid/ready handshake, decodes CB xx, computes the result and flags, and writes the register file back.
- On retirement, emits the z80fi retirement record (valid, insn, insn_len, register in/out snapshots) consumed by the formal instruction specs.
- Register-operand forms only; (HL) forms (r == 6) trap to the microcoded memory path.

---
 rtl/z80_cb_shift_exec_pkg.sv | 67 ++++++
 rtl/z80_cb_shift_exec_if.sv | 9 +
 rtl/z80_cb_shift_exec_shift8.sv | 28 ++
 rtl/z80_cb_shift_exec.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/z80_cb_shift_exec_pkg.sv
// Shared definitions for the CB-prefixed shift/rotate execution unit:
// operand register codes, flag bit positions, shift-op encodings and helpers.
package z80_cb_shift_exec_pkg;

  localparam logic [7:0] CB_PREFIX_DEFAULT = 8'hCB;

  // Operand codes from opcode[2:0]; 6 is the (HL) memory form.
  localparam logic [2:0] REG_B  = 3'd0;
  localparam logic [2:0] REG_C  = 3'd1;
  localparam logic [2:0] REG_D  = 3'd2;
  localparam logic [2:0] REG_E  = 3'd3;
  localparam logic [2:0] REG_H  = 3'd4;
  localparam logic [2:0] REG_L  = 3'd5;
  localparam logic [2:0] REG_HL = 3'd6;
  localparam logic [2:0] REG_A  = 3'd7;

  // Bit offset of F inside the packed {A,F,B,C,D,E,H,L} register word.
  localparam int unsigned F_LSB = 48;

  localparam int unsigned FLAG_C_NUM  = 0;
  localparam int unsigned FLAG_N_NUM  = 1;
  localparam int unsigned FLAG_PV_NUM = 2;
  localparam int unsigned FLAG_F3_NUM = 3;
  localparam int unsigned FLAG_H_NUM  = 4;
  localparam int unsigned FLAG_F5_NUM = 5;
  localparam int unsigned FLAG_Z_NUM  = 6;
  localparam int unsigned FLAG_S_NUM  = 7;

  typedef enum logic [2:0] {
    OP_RLC = 3'd0,
    OP_RRC = 3'd1,
    OP_RL  = 3'd2,
    OP_RR  = 3'd3,
    OP_SLA = 3'd4,
    OP_SRA = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OP     = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

  // Returns 1 when v has an even number of set bits (Z80 PV after shifts).
  function automatic logic parity8(input logic [7:0] v);
    return ~^v;
  endfunction

  function automatic logic [5:0] reg_lsb(input logic [2:0] r);
    logic [5:0] lsb;
    case (r)
      REG_B:   lsb = 6'd40;
      REG_C:   lsb = 6'd32;
      REG_D:   lsb = 6'd24;
      REG_E:   lsb = 6'd16;
      REG_H:   lsb = 6'd8;
      REG_L:   lsb = 6'd0;
      REG_A:   lsb = 6'd56;
      default: lsb = 6'd0;
    endcase
    return lsb;
  endfunction

endpackage

// File: rtl/z80_cb_shift_exec_if.sv
// Fetch-stage byte stream handshake: a byte moves when fetch_valid && fetch_ready.
interface z80_cb_shift_exec_if;
  logic       fetch_valid;
  logic [7:0] fetch_byte;
  logic       fetch_ready;

  modport master (output fetch_valid, output fetch_byte, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_byte, output fetch_ready);
endinterface

// File: rtl/z80_cb_shift_exec_shift8.sv
// Combinational 8-bit Z80 shift/rotate datapath, shared with the indexed CB path.
module z80_shift8
  import z80_cb_shift_exec_pkg::*;
(
  input  logic [7:0] d,
  input  shift_op_e  op,
  input  logic       cin,
  output logic [7:0] res,
  output logic       cout
);

  always_comb begin
    res  = d;
    cout = 1'b0;
    case (op)
      OP_RLC: begin res = {d[6:0], d[7]};  cout = d[7]; end
      OP_RRC: begin res = {d[0], d[7:1]};  cout = d[0]; end
      OP_RL:  begin res = {d[6:0], cin};   cout = d[7]; end
      OP_RR:  begin res = {cin, d[7:1]};   cout = d[0]; end
      OP_SLA: begin res = {d[6:0], 1'b0};  cout = d[7]; end
      OP_SRA: begin res = {d[7], d[7:1]};  cout = d[0]; end
      OP_SLL: begin res = {d[6:0], 1'b1};  cout = d[7]; end
      OP_SRL: begin res = {1'b0, d[7:1]};  cout = d[0]; end
      default: begin res = d; cout = 1'b0; end
    endcase
  end

endmodule

// File: rtl/z80_cb_shift_exec.sv
// CB xx shift/rotate execution unit: decodes the prefixed opcode, computes the
// result and flags, writes back the register file and emits the z80fi record.
module z80_cb_shift_exec
  import z80_cb_shift_exec_pkg::*;
#(
  parameter logic [7:0] CB_PREFIX = CB_PREFIX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  z80_cb_shift_exec_if.slave       fetch,
  input  logic [63:0]              regs_in,
  input  logic [15:0]              ip_in,
  output logic [63:0]              regs_out,
  output logic [15:0]              ip_out,
  output logic                     wb_valid,
  output logic                     not_mine,
  output logic                     trap_hl,
  output logic                     z80fi_valid,
  output logic [31:0]              z80fi_insn,
  output logic [2:0]               z80fi_insn_len,
  output logic [63:0]              z80fi_regs_in,
  output logic [63:0]              z80fi_regs_out,
  output logic [15:0]              z80fi_ip_in,
  output logic [15:0]              z80fi_ip_out
);

  state_e      state_q, state_d;
  logic        not_mine_q, not_mine_d;
  logic        trap_hl_q, trap_hl_d;
  logic        wb_valid_q, wb_valid_d;
  logic        latch_op;
  logic        commit;

  logic [7:0]  opcode_q;
  logic [63:0] snap_regs_q;
  logic [15:0] snap_ip_q;
  logic [63:0] regs_out_q;
  logic [15:0] ip_out_q;
  logic [31:0] insn_q;
  logic [2:0]  insn_len_q;

  logic [2:0]  r_sel;
  logic [5:0]  r_lsb;
  logic [7:0]  operand;
  logic [7:0]  f_in;
  logic [7:0]  shift_res;
  logic        shift_cout;
  logic [7:0]  flags;
  logic [63:0] new_regs;

  always_comb begin
    state_d     = state_q;
    fetch.fetch_ready = 1'b0;
    not_mine_d  = 1'b0;
    trap_hl_d   = 1'b0;
    wb_valid_d  = 1'b0;
    latch_op    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fetch.fetch_ready = 1'b1;
        if (fetch.fetch_valid) begin
          if (fetch.fetch_byte == CB_PREFIX) state_d = ST_OP;
          else                                not_mine_d = 1'b1;
        end
      end
      ST_OP: begin
        fetch.fetch_ready = 1'b1;
        if (fetch.fetch_valid) begin
          latch_op = 1'b1;
          // BIT/RES/SET live in a different unit.
          if (fetch.fetch_byte[7:6] != 2'b00) begin
            not_mine_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (opcode_q[2:0] == REG_HL) begin
          trap_hl_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          commit  = 1'b1;
          state_d = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        wb_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r_sel   = opcode_q[2:0];
  assign r_lsb   = reg_lsb(r_sel);
  assign operand = snap_regs_q[r_lsb +: 8];
  assign f_in    = snap_regs_q[F_LSB +: 8];

  z80_shift8 u_shift8 (
    .d    (operand),
    .op   (shift_op_e'(opcode_q[5:3])),
    .cin  (f_in[FLAG_C_NUM]),
    .res  (shift_res),
    .cout (shift_cout)
  );

  always_comb begin
    flags              = 8'h00;
    flags[FLAG_S_NUM]  = shift_res[7];
    flags[FLAG_Z_NUM]  = (shift_res == 8'h00);
    flags[FLAG_F5_NUM] = f_in[FLAG_F5_NUM];
    flags[FLAG_H_NUM]  = 1'b0;
    flags[FLAG_F3_NUM] = f_in[FLAG_F3_NUM];
    flags[FLAG_PV_NUM] = parity8(shift_res);
    flags[FLAG_N_NUM]  = 1'b0;
    flags[FLAG_C_NUM]  = shift_cout;
    new_regs             = snap_regs_q;
    new_regs[r_lsb +: 8] = shift_res;
    new_regs[F_LSB +: 8] = flags;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      not_mine_q  <= 1'b0;
      trap_hl_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      opcode_q    <= 8'h00;
      snap_regs_q <= 64'h0;
      snap_ip_q   <= 16'h0;
      regs_out_q  <= 64'h0;
      ip_out_q    <= 16'h0;
      insn_q      <= 32'h0;
      insn_len_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      not_mine_q <= not_mine_d;
      trap_hl_q  <= trap_hl_d;
      wb_valid_q <= wb_valid_d;
      if (latch_op) begin
        opcode_q    <= fetch.fetch_byte;
        snap_regs_q <= regs_in;
        snap_ip_q   <= ip_in;
      end
      // Results are held stable until the next commit so wb_valid can sample them.
      if (commit) begin
        regs_out_q <= new_regs;
        ip_out_q   <= snap_ip_q + 16'd2;
        insn_q     <= {16'h0000, opcode_q, CB_PREFIX};
        insn_len_q <= 3'd2;
      end
    end
  end

  // The retirement snapshot of the inputs is taken from the OP-accept latch.
  logic [63:0] fi_regs_in_q;
  logic [15:0] fi_ip_in_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fi_regs_in_q <= 64'h0;
      fi_ip_in_q   <= 16'h0;
    end else if (commit) begin
      fi_regs_in_q <= snap_regs_q;
      fi_ip_in_q   <= snap_ip_q;
    end
  end

  assign regs_out       = regs_out_q;
  assign ip_out         = ip_out_q;
  assign wb_valid       = wb_valid_q;
  assign not_mine       = not_mine_q;
  assign trap_hl        = trap_hl_q;
  assign z80fi_valid    = wb_valid_q;
  assign z80fi_insn     = insn_q;
  assign z80fi_insn_len = insn_len_q;
  assign z80fi_regs_in  = fi_regs_in_q;
  assign z80fi_regs_out = regs_out_q;
  assign z80fi_ip_in    = fi_ip_in_q;
  assign z80fi_ip_out   = ip_out_q;

endmodule
